instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/pc_reg.sv | 25 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, fetch states,
// instruction field positions and the default halt word.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RA_LSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    OPC_0 = 3'b000,
    OPC_1 = 3'b001,
    OPC_2 = 3'b010,
    OPC_3 = 3'b011,
    OPC_4 = 3'b100,
    OPC_5 = 3'b101,
    OPC_6 = 3'b110,
    OPC_7 = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

  function automatic logic [2:0] ir_op(input logic [INSTR_W-1:0] ir);
    return ir[OP_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_rd(input logic [INSTR_W-1:0] ir);
    return ir[RD_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_ra(input logic [INSTR_W-1:0] ir);
    return ir[RA_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_rb(input logic [INSTR_W-1:0] ir);
    return ir[RB_LSB +: 3];
  endfunction

  function automatic logic [3:0] ir_imm(input logic [INSTR_W-1:0] ir);
    return ir[IMM_LSB +: 4];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: cleared on (re)start, otherwise advances by one with wrap
// or loads a branch target when the current instruction retires.
module pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              br_en,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (load) begin
      pc <= br_en ? br_addr : pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/decode sequencer: fetches one word at a time, presents the
// decoded fields until the execute stage consumes them, and stops on the halt word.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                   ADDR_W    = 8,
  parameter logic [INSTR_W-1:0]   HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [2:0]         op,
  output logic [2:0]         rd,
  output logic [2:0]         ra,
  output logic [2:0]         rb,
  output logic [3:0]         imm,
  output logic               valid,
  input  logic               adv,
  input  logic               br_en,
  input  logic [ADDR_W-1:0]  br_addr,
  output logic               halted,
  output logic [15:0]        ret_cnt
);

  fetch_state_e       state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               restart;
  logic               retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt = ST_FETCH;
          restart   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_nxt = (imem_data == HALT_WORD) ? ST_HALT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (adv) begin
          state_nxt = ST_FETCH;
          retire    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // IR only captures on an acknowledged fetch, so stray acks leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (state == ST_FETCH && imem_ack) begin
      ir <= imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cnt <= '0;
    end else if (restart) begin
      ret_cnt <= '0;
    end else if (retire && ret_cnt != 16'hFFFF) begin
      ret_cnt <= ret_cnt + 16'd1;
    end
  end

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (restart),
    .load   (retire),
    .br_en  (br_en),
    .br_addr(br_addr),
    .pc     (imem_addr)
  );

  assign imem_req = (state == ST_FETCH);
  assign valid    = (state == ST_EXEC);
  assign halted   = (state == ST_HALT);

  assign op  = ir_op(ir);
  assign rd  = ir_rd(ir);
  assign ra  = ir_ra(ir);
  assign rb  = ir_rb(ir);
  assign imm = ir_imm(ir);

endmodule
